mcp_dal_resp: RTL and testbench

- DAL-side bus responder: the target end of the data chip's address/data strobe interface.
- Latches the address on pin_astb and executes a read or write on pin_dstb against an internal word memory.
- Stalls the microbus through pin_wi for a programmable number of wait states, then returns read data on pin_adi.
- Serves as the memory/I-O model in LSI microbus simulations and the FPGA bring-up top.

---
 rtl/mcp_dal_resp.sv | 171 +++++++++++++++++
 tb/tb_mcp_dal_resp.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcp_dal_resp.sv
// mcp_dal_resp: target end of the data chip's address/data strobe bus.
// pin_astb latches pin_ado as the address. pin_dstb starts a read or write
// against an internal 16-bit word memory. The bus is stalled through pin_wi for
// WAIT_CYC cycles, and the access then completes with a single-cycle
// pin_rply or pin_err pulse.
//
// Ports:
//   pin_clk_p   in   1  clock, rising edge
//   pin_init_n  in   1  asynchronous active-low reset
//   pin_ado     in  16  address (with pin_astb) or write data (with pin_dstb)
//   pin_astb    in   1  address strobe
//   pin_dstb    in   1  data strobe
//   pin_wr      in   1  1 = write, 0 = read (sampled with pin_dstb)
//   pin_bt      in   1  1 = byte write (sampled with pin_dstb)
//   pin_adi     out 16  registered read data
//   pin_wi      out  1  registered wait request
//   pin_rply    out  1  access completed pulse
//   pin_err     out  1  bus error pulse
module mcp_dal_resp #(
    parameter int DEPTH    = 1024,
    parameter int WAIT_CYC = 2
) (
    input  logic        pin_clk_p,
    input  logic        pin_init_n,
    input  logic [15:0] pin_ado,
    input  logic        pin_astb,
    input  logic        pin_dstb,
    input  logic        pin_wr,
    input  logic        pin_bt,
    output logic [15:0] pin_adi,
    output logic        pin_wi,
    output logic        pin_rply,
    output logic        pin_err
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] areg_q, areg_d;
    logic [15:0] wreg_q, wreg_d;
    logic        wr_q, wr_d;
    logic        bt_q, bt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] adi_q;
    logic        wi_q, rply_q, err_q;

    logic [15:0]      mem_q [DEPTH];
    logic [14:0]      widx;
    logic             in_range;
    logic             mem_we;
    logic             mem_re;
    logic             err_d;
    logic [1:0]       lane_we;
    logic [1:0][7:0]  lane_data;

    // Byte address bit 0 only selects a lane for byte writes.
    assign widx     = areg_q[15:1];
    assign in_range = ({17'd0, widx} < 32'($unsigned(DEPTH)));
    assign mem_we   = (state_q == ST_DONE) && in_range && wr_q;
    assign mem_re   = (state_q == ST_DONE) && in_range && !wr_q;

    // A data strobe with no address phase is an error. So is any access
    // outside the memory.
    assign err_d = ((state_q == ST_IDLE) && pin_dstb && !pin_astb) ||
                   ((state_q == ST_DONE) && !in_range);

    // Byte writes always take their data from the low lane of the write data.
    // areg[0] chooses which memory byte receives it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign lane_we[gi]   = mem_we && (!bt_q || (areg_q[0] == 1'(gi)));
        assign lane_data[gi] = bt_q ? wreg_q[7:0] : wreg_q[gi*8 +: 8];
    end

    always_comb begin
        state_d = state_q;
        areg_d  = areg_q;
        wreg_d  = wreg_q;
        wr_d    = wr_q;
        bt_d    = bt_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pin_astb) begin
                    areg_d  = pin_ado;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // An address strobe has priority over a simultaneous data strobe.
                if (pin_astb) begin
                    areg_d = pin_ado;
                end else if (pin_dstb) begin
                    wreg_d = pin_ado;
                    wr_d   = pin_wr;
                    bt_d   = pin_bt;
                    if (WAIT_CYC == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                // The address is kept, so a following data strobe reuses it.
                state_d = ST_ADDR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pin_clk_p or negedge pin_init_n) begin
        if (!pin_init_n) begin
            state_q <= ST_IDLE;
            areg_q  <= 16'd0;
            wreg_q  <= 16'd0;
            wr_q    <= 1'b0;
            bt_q    <= 1'b0;
            cnt_q   <= 4'd0;
            adi_q   <= 16'd0;
            wi_q    <= 1'b0;
            rply_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            areg_q  <= areg_d;
            wreg_q  <= wreg_d;
            wr_q    <= wr_d;
            bt_q    <= bt_d;
            cnt_q   <= cnt_d;
            // Registered outputs trail the state by one cycle. pin_wi covers
            // the WAIT cycles, and the reply lands on the edge that leaves DONE.
            wi_q    <= (state_q == ST_WAIT);
            rply_q  <= (state_q == ST_DONE) && in_range;
            err_q   <= err_d;
            if (mem_re) begin
                adi_q <= mem_q[widx[AW-1:0]];
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge pin_clk_p) begin
        for (int b = 0; b < 2; b++) begin
            if (lane_we[b]) begin
                mem_q[widx[AW-1:0]][b*8 +: 8] <= lane_data[b];
            end
        end
    end

    assign pin_adi  = adi_q;
    assign pin_wi   = wi_q;
    assign pin_rply = rply_q;
    assign pin_err  = err_q;

endmodule

// File: tb/tb_mcp_dal_resp.sv
// Bench for mcp_dal_resp. Three instances share clock and reset:
// u0 with WAIT_CYC=2, u1 with WAIT_CYC=0 and u2 with WAIT_CYC=15.
// u0 is tracked every cycle by a time-stamped transaction model.
module tb_mcp_dal_resp;

    localparam int DEPTH = 1024;
    localparam int W0    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        astb_v [3];
    logic        dstb_v [3];
    logic        wr_v   [3];
    logic        bt_v   [3];
    logic [15:0] ado_v  [3];
    wire  [15:0] adi_v  [3];
    wire         wi_v   [3];
    wire         rply_v [3];
    wire         err_v  [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int WC = (gi == 0) ? 2 : ((gi == 1) ? 0 : 15);
        mcp_dal_resp #(.DEPTH(DEPTH), .WAIT_CYC(WC)) u_dut (
            .pin_clk_p (clk),
            .pin_init_n(rst_n),
            .pin_ado   (ado_v[gi]),
            .pin_astb  (astb_v[gi]),
            .pin_dstb  (dstb_v[gi]),
            .pin_wr    (wr_v[gi]),
            .pin_bt    (bt_v[gi]),
            .pin_adi   (adi_v[gi]),
            .pin_wi    (wi_v[gi]),
            .pin_rply  (rply_v[gi]),
            .pin_err   (err_v[gi])
        );
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model for u0 ----------------
    // The model knows whether an address has been seen since reset and the
    // edge at which an access was accepted. Completion and wait window are
    // derived from that time stamp.
    logic [15:0] mmem [DEPTH];
    int          m_cyc       = 0;
    int          m_start     = 0;
    bit          m_addressed = 0;
    bit          m_pending   = 0;
    logic [15:0] m_addr      = 16'd0;
    logic [15:0] m_data      = 16'd0;
    bit          m_wr        = 0;
    bit          m_bt        = 0;
    logic [15:0] e_adi       = 16'd0;
    bit          e_wi        = 0;
    bit          e_rply      = 0;
    bit          e_err       = 0;
    bit          cmp_en      = 0;

    initial begin
        int widx;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_addressed = 0;
                m_pending   = 0;
                e_adi       = 16'd0;
                e_wi        = 0;
                e_rply      = 0;
                e_err       = 0;
            end else begin
                m_cyc++;
                e_rply = 0;
                e_err  = 0;
                if (m_pending && (m_cyc == m_start + W0 + 1)) begin
                    m_pending = 0;
                    widx      = int'(m_addr) / 2;
                    if (widx < DEPTH) begin
                        e_rply = 1;
                        if (!m_wr)      e_adi = mmem[widx];
                        else if (!m_bt) mmem[widx] = m_data;
                        else if (m_addr[0]) mmem[widx][15:8] = m_data[7:0];
                        else            mmem[widx][7:0] = m_data[7:0];
                    end else begin
                        e_err = 1;
                    end
                end else if (!m_pending) begin
                    if (astb_v[0]) begin
                        m_addr      = ado_v[0];
                        m_addressed = 1;
                    end else if (dstb_v[0]) begin
                        if (!m_addressed) begin
                            e_err = 1;
                        end else begin
                            m_pending = 1;
                            m_start   = m_cyc;
                            m_data    = ado_v[0];
                            m_wr      = wr_v[0];
                            m_bt      = bt_v[0];
                        end
                    end
                end
                e_wi = m_pending && (m_cyc >= m_start + 1) && (m_cyc <= m_start + W0);
            end
        end
    end

    // Cycle-by-cycle comparison of u0 against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cmp_en) begin
                check("cyc_adi",  32'(adi_v[0]),  32'(e_adi));
                check("cyc_wi",   32'(wi_v[0]),   32'(e_wi));
                check("cyc_rply", 32'(rply_v[0]), 32'(e_rply));
                check("cyc_err",  32'(err_v[0]),  32'(e_err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int          r_lat;
    int          r_wcnt;
    bit          r_rp;
    bit          r_er;
    bit          r_pulse;
    logic [15:0] r_adi;

    task automatic idle_all();
        for (int u = 0; u < 3; u++) begin
            astb_v[u] = 1'b0;
            dstb_v[u] = 1'b0;
            wr_v[u]   = 1'b0;
            bt_v[u]   = 1'b0;
            ado_v[u]  = 16'd0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_all();
        @(negedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check("rst_adi",  32'(adi_v[u]),  32'd0);
            check("rst_wi",   32'(wi_v[u]),   32'd0);
            check("rst_rply", 32'(rply_v[u]), 32'd0);
            check("rst_err",  32'(err_v[u]),  32'd0);
        end
        rst_n = 1'b1;
    endtask

    task automatic strobe_addr(input int u, input logic [15:0] a);
        @(negedge clk);
        astb_v[u] = 1'b1;
        ado_v[u]  = a;
        @(negedge clk);
        astb_v[u] = 1'b0;
    endtask

    // Drives a data strobe for one cycle and returns at the negedge of the
    // cycle right after the sampling edge.
    task automatic strobe_data(input int u, input bit wr, input bit bt, input logic [15:0] d);
        dstb_v[u] = 1'b1;
        wr_v[u]   = wr;
        bt_v[u]   = bt;
        ado_v[u]  = d;
        @(negedge clk);
        dstb_v[u] = 1'b0;
        wr_v[u]   = 1'b0;
        bt_v[u]   = 1'b0;
    endtask

    // Watches for the reply starting at offset k0 after the data edge.
    task automatic collect(input int u, input int k0);
        r_lat   = -1;
        r_wcnt  = 0;
        r_rp    = 0;
        r_er    = 0;
        r_adi   = adi_v[u];
        for (int k = k0; k < 40; k++) begin
            if (k > k0) @(negedge clk);
            if (wi_v[u]) r_wcnt++;
            if (rply_v[u] || err_v[u]) begin
                r_lat = k;
                r_rp  = rply_v[u];
                r_er  = err_v[u];
                r_adi = adi_v[u];
                break;
            end
        end
        @(negedge clk);
        r_pulse = (r_lat >= 0) && !rply_v[u] && !err_v[u];
    endtask

    task automatic access(input int u, input bit wr, input bit bt,
                          input logic [15:0] a, input logic [15:0] d);
        strobe_addr(u, a);
        strobe_data(u, wr, bt, d);
        collect(u, 0);
    endtask

    task automatic do_wr(input int u, input logic [15:0] a, input logic [15:0] d,
                         input bit bt, input int w);
        access(u, 1'b1, bt, a, d);
        $display("[TB] wr u%0d addr=%04h data=%04h bt=%0d lat=%0d wi=%0d", u, a, d, bt, r_lat, r_wcnt);
        check("wr_lat",   32'(r_lat),   32'(w + 1));
        check("wr_wi",    32'(r_wcnt),  32'(w));
        check("wr_rply",  32'(r_rp),    32'd1);
        check("wr_err",   32'(r_er),    32'd0);
        check("wr_pulse", 32'(r_pulse), 32'd1);
    endtask

    task automatic do_rd(input int u, input logic [15:0] a, input logic [15:0] exp, input int w);
        access(u, 1'b0, 1'b0, a, 16'h0000);
        $display("[TB] rd u%0d addr=%04h adi=%04h lat=%0d wi=%0d", u, a, r_adi, r_lat, r_wcnt);
        check("rd_adi",   32'(r_adi),   32'(exp));
        check("rd_lat",   32'(r_lat),   32'(w + 1));
        check("rd_wi",    32'(r_wcnt),  32'(w));
        check("rd_rply",  32'(r_rp),    32'd1);
        check("rd_err",   32'(r_er),    32'd0);
        check("rd_pulse", 32'(r_pulse), 32'd1);
        if (u == 0) check("model_adi", 32'(e_adi), 32'(exp));
    endtask

    // Data strobe with no address since reset.
    task automatic dstb_alone(input logic [15:0] prev_adi);
        @(negedge clk);
        strobe_data(0, 1'b0, 1'b0, 16'h0000);
        $display("[TB] orphan dstb err=%0d rply=%0d adi=%04h", err_v[0], rply_v[0], adi_v[0]);
        check("orphan_err",  32'(err_v[0]),  32'd1);
        check("orphan_rply", 32'(rply_v[0]), 32'd0);
        check("orphan_adi",  32'(adi_v[0]),  32'(prev_adi));
        check("model_orphan_err", 32'(e_err), 32'd1);
        @(negedge clk);
        check("orphan_pulse", 32'(err_v[0]), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet;
        idle_all();
        do_reset();
        cmp_en = 1;

        // Basic word write and read back.
        do_wr(0, 16'h0010, 16'hA5C3, 1'b0, W0);
        do_rd(0, 16'h0010, 16'hA5C3, W0);

        // Byte lanes.
        do_wr(0, 16'h0020, 16'h1234, 1'b0, W0);
        do_wr(0, 16'h0021, 16'h00FF, 1'b1, W0);
        do_rd(0, 16'h0020, 16'hFF34, W0);
        do_wr(0, 16'h0020, 16'h0077, 1'b1, W0);
        do_rd(0, 16'h0020, 16'hFF77, W0);

        // Orphan data strobe right after reset.
        do_reset();
        dstb_alone(16'h0000);

        // Out-of-range write must not alias onto word 0.
        do_wr(0, 16'h0000, 16'h5555, 1'b0, W0);
        do_rd(0, 16'h0000, 16'h5555, W0);
        access(0, 1'b1, 1'b0, 16'h0800, 16'hDEAD);
        $display("[TB] wr u0 addr=0800 out of range err=%0d rply=%0d", r_er, r_rp);
        check("oor_err",  32'(r_er),  32'd1);
        check("oor_rply", 32'(r_rp),  32'd0);
        check("oor_lat",  32'(r_lat), 32'(W0 + 1));
        check("oor_adi",  32'(r_adi), 32'h5555);
        do_rd(0, 16'h0000, 16'h5555, W0);

        // Address and data strobes together in ADDR: reload only.
        do_wr(0, 16'h0030, 16'h1111, 1'b0, W0);
        do_wr(0, 16'h0032, 16'h2222, 1'b0, W0);
        strobe_addr(0, 16'h0030);
        astb_v[0] = 1'b1;
        ado_v[0]  = 16'h0032;
        strobe_data(0, 1'b1, 1'b0, 16'h0032);
        astb_v[0] = 1'b0;
        quiet = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (wi_v[0] || rply_v[0] || err_v[0]) quiet = 0;
        end
        check("collide_quiet", 32'(quiet), 32'd1);
        strobe_data(0, 1'b0, 1'b0, 16'h0000);
        collect(0, 0);
        $display("[TB] rd u0 after collision adi=%04h rply=%0d", r_adi, r_rp);
        check("collide_adi",  32'(r_adi), 32'h2222);
        check("collide_rply", 32'(r_rp),  32'd1);
        do_rd(0, 16'h0030, 16'h1111, W0);

        // Address strobe during WAIT is ignored.
        strobe_addr(0, 16'h0030);
        strobe_data(0, 1'b0, 1'b0, 16'h0000);
        astb_v[0] = 1'b1;
        ado_v[0]  = 16'h0032;
        @(negedge clk);
        astb_v[0] = 1'b0;
        collect(0, 1);
        $display("[TB] rd u0 astb in wait adi=%04h lat=%0d", r_adi, r_lat);
        check("waitastb_adi", 32'(r_adi), 32'h1111);
        check("waitastb_lat", 32'(r_lat), 32'(W0 + 1));

        // Reset in the middle of a write.
        do_wr(0, 16'h0040, 16'h0BAD, 1'b0, W0);
        do_rd(0, 16'h0040, 16'h0BAD, W0);
        strobe_addr(0, 16'h0040);
        strobe_data(0, 1'b1, 1'b0, 16'hBEEF);
        @(negedge clk);
        check("midwait_wi", 32'(wi_v[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        $display("[TB] reset mid-wait adi=%04h wi=%0d rply=%0d", adi_v[0], wi_v[0], rply_v[0]);
        check("midrst_adi",  32'(adi_v[0]),  32'd0);
        check("midrst_wi",   32'(wi_v[0]),   32'd0);
        check("midrst_rply", 32'(rply_v[0]), 32'd0);
        for (int k = 0; k < 4; k++) @(negedge clk);
        check("midrst_norply", 32'(rply_v[0]), 32'd0);
        rst_n = 1'b1;
        dstb_alone(16'h0000);
        do_rd(0, 16'h0040, 16'h0BAD, W0);

        // Zero and maximum wait states.
        do_wr(1, 16'h0010, 16'h0001, 1'b0, 0);
        do_rd(1, 16'h0010, 16'h0001, 0);
        do_wr(2, 16'h0010, 16'h00F0, 1'b0, 15);
        do_rd(2, 16'h0010, 16'h00F0, 15);

        // Randomised traffic on u0. Words 0..15 are loaded first, so that
        // every in-range read hits a known value.
        for (int i = 0; i < 16; i++) do_wr(0, 16'(i * 2), 16'($urandom), 1'b0, W0);
        for (int c = 0; c < 3000; c++) begin
            int r;
            @(negedge clk);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                idle_all();
                @(negedge clk);
                rst_n = 1'b1;
                continue;
            end
            r         = int'($urandom_range(0, 99));
            astb_v[0] = (r < 20);
            dstb_v[0] = (r >= 15) && (r < 45);
            wr_v[0]   = 1'($urandom);
            bt_v[0]   = 1'($urandom);
            if (astb_v[0]) begin
                if ($urandom_range(0, 9) == 0) ado_v[0] = 16'(32'h0800 + $urandom_range(0, 32'hF7FF));
                else                           ado_v[0] = 16'($urandom_range(0, 31));
            end else begin
                ado_v[0] = 16'($urandom);
            end
        end
        @(negedge clk);
        idle_all();
        for (int k = 0; k < 25; k++) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
